imem_load_arbiter: RTL and testbench



---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_load_arbiter_if.sv | 26 ++
 rtl/imem_ram.sv | 22 ++
 rtl/imem_load_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_load_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the writable instruction memory and its load arbiter.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
        RUN   = 3'd4
    } imem_state_e;

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Loader handshake plus RAM port bundle; master = arbiter, slave = loader/RAM side.
interface imem_load_arbiter_if import imem_pkg::*; #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  ld_valid, ld_data, ld_last, mem_rdata,
        output ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport slave (
        output ld_valid, ld_data, ld_last, mem_rdata,
        input  ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write, asynchronous read, no reset on contents.
module imem_ram import imem_pkg::*; #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction RAM between the program loader and IF fetch; holds the
// pipeline until a complete program (optionally zero-padded) is resident.
//
//   state | meaning
//   IDLE  | no program, CPU held, waiting for load_start
//   LOAD  | accepting loader beats, one registered write per beat
//   FILL  | writing NOP to every index after the last loaded word
//   FLUSH | one cycle for the final registered write to land
//   RUN   | program resident, CPU released, fetches served from RAM
module imem_load_arbiter import imem_pkg::*; #(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int ZERO_FILL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic [31:0]          fetch_addr,
    output logic [DATA_W-1:0]    fetch_instr,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic [ADDR_W:0]      load_count,
    output logic                 err_overflow,
    imem_load_arbiter_if.master  bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_FILL  = FILL;
    localparam logic [2:0] S_FLUSH = FLUSH;
    localparam logic [2:0] S_RUN   = RUN;

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    logic [2:0]        state_q,      state_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic [ADDR_W-1:0] fill_idx_q,   fill_idx_d;
    logic              err_q,        err_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q,  mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              cpu_hold_q,   cpu_hold_d;
    logic              load_done_q,  load_done_d;

    logic ld_ready_w;
    logic beat_w;
    logic last_idx_w;

    // Ready drops once every index has been claimed, even before the state moves on.
    assign ld_ready_w = (state_q == S_LOAD) && (load_count_q != CNT_FULL);
    assign beat_w     = ld_ready_w && bus.ld_valid;
    assign last_idx_w = (load_count_q[ADDR_W-1:0] == IDX_LAST);

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        fill_idx_d   = fill_idx_q;
        err_d        = err_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            S_LOAD: begin
                if (beat_w) begin
                    mem_we_d     = 1'b1;
                    mem_waddr_d  = load_count_q[ADDR_W-1:0];
                    mem_wdata_d  = bus.ld_data;
                    load_count_d = load_count_q + CNT_ONE;
                    fill_idx_d   = load_count_q[ADDR_W-1:0] + IDX_ONE;
                    if (bus.ld_last) begin
                        state_d = ((ZERO_FILL != 0) && !last_idx_w) ? S_FILL : S_FLUSH;
                    end else if (last_idx_w) begin
                        err_d   = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FILL: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = fill_idx_q;
                mem_wdata_d = DATA_W'(IMEM_NOP);
                fill_idx_d  = fill_idx_q + IDX_ONE;
                if (fill_idx_q == IDX_LAST) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so both flip on the same edge as the state.
        cpu_hold_d  = (state_d != S_RUN);
        load_done_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_count_q <= '0;
            fill_idx_q   <= '0;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            fill_idx_q   <= fill_idx_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
        end
    end

    assign bus.ld_ready  = ld_ready_w;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Word index only; byte offset and high PC bits are dropped so fetches wrap.
    assign bus.mem_raddr = fetch_addr[ADDR_W+1:2];

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    assign fetch_instr  = (state_q == S_RUN) ? bus.mem_rdata : DATA_W'(IMEM_NOP);
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_count   = load_count_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Randomized/directed bench for imem_load_arbiter against a word-level memory model.
module tb_imem_load_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic        load_done;
    logic [8:0]  load_count;
    logic        err_overflow;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] ld_words  [DEPTH];

    imem_load_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ZERO_FILL(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_count   (load_count),
        .err_overflow (err_overflow),
        .bus          (bus)
    );

    imem_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk   (clk),
        .we    (bus.mem_we),
        .waddr (bus.mem_waddr),
        .wdata (bus.mem_wdata),
        .raddr (bus.mem_raddr),
        .rdata (bus.mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every write must land at the next sequential index with the word the model expects.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            chk("wr_idx", 64'(bus.mem_waddr), 64'(wr_cnt));
            chk("wr_data", 64'(bus.mem_wdata), 64'(model_mem[bus.mem_waddr]));
            chk("wr_in_run", 64'(load_done), 64'd0);
            wr_cnt++;
        end
    end

    task automatic fetch_chk(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        fetch_addr = a;
        #1;
        chk("fetch", 64'(fetch_instr), 64'(model_mem[idx]));
    endtask

    // gap_mode: 0 = back-to-back beats, 1 = valid drops between beats, 2 = random drops.
    task automatic do_load(input int n, input bit has_last, input int gap_mode, input int abort_at);
        int  fill;
        int  cycles;
        bit  gap;
        bit  hit;
        fill = (has_last && n < DEPTH) ? DEPTH - n : 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < n)         model_mem[i] = ld_words[i];
            else if (has_last) model_mem[i] = 32'h0;
        end

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wr_cnt = 0;
        chk("start_hold", 64'(cpu_hold), 64'd1);
        chk("start_instr", 64'(fetch_instr), 64'd0);
        chk("start_done", 64'(load_done), 64'd0);
        chk("start_count", 64'(load_count), 64'd0);
        chk("start_err", 64'(err_overflow), 64'd0);

        for (int i = 0; i < n; i++) begin
            gap = (gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
            if (gap) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = $urandom;
                bus.ld_last  = 1'($urandom_range(0, 1));
                load_start   = 1'b1;
                tick();
                load_start   = 1'b0;
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = ld_words[i];
            bus.ld_last  = has_last && (i == n - 1);
            chk("ld_ready", 64'(bus.ld_ready), 64'd1);
            tick();
            chk("beat_count", 64'(load_count), 64'(i + 1));
        end

        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        cycles = 1;
        hit = 1'b0;
        while (!load_done && cycles < 600 && !hit) begin
            if (abort_at >= 0 && bus.mem_we === 1'b1 && bus.mem_waddr == abort_at[7:0]) begin
                hit = 1'b1;
            end else begin
                chk("rdy_low", 64'(bus.ld_ready), 64'd0);
                bus.ld_valid = 1'($urandom_range(0, 1));
                bus.ld_data  = $urandom;
                load_start   = (cycles == 3 && fill > 4) || (cycles == fill + 1);
                tick();
                load_start   = 1'b0;
                cycles++;
            end
        end
        bus.ld_valid = 1'b0;

        if (abort_at >= 0) begin
            chk("abort_hit", 64'(hit), 64'd1);
            reset = 1'b1;
            tick();
            chk("rst_we", 64'(bus.mem_we), 64'd0);
            chk("rst_count", 64'(load_count), 64'd0);
            chk("rst_hold", 64'(cpu_hold), 64'd1);
            chk("rst_done", 64'(load_done), 64'd0);
            chk("rst_ready", 64'(bus.ld_ready), 64'd0);
            chk("rst_instr", 64'(fetch_instr), 64'd0);
            reset = 1'b0;
            return;
        end

        chk("done_latency", 64'(cycles), 64'(fill + 2));
        chk("done", 64'(load_done), 64'd1);
        chk("run_hold", 64'(cpu_hold), 64'd0);
        chk("run_count", 64'(load_count), 64'(n));
        chk("run_err", 64'(err_overflow), 64'(!has_last && n == DEPTH));
        chk("write_total", 64'(wr_cnt), 64'(n + fill));
        chk("run_ready", 64'(bus.ld_ready), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        load_start   = 1'b0;
        fetch_addr   = 32'h0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 32'h0;
        bus.ld_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_hold", 64'(cpu_hold), 64'd1);
        chk("rst_ready", 64'(bus.ld_ready), 64'd0);
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        chk("rst_waddr", 64'(bus.mem_waddr), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_count", 64'(load_count), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        chk("rst_instr", 64'(fetch_instr), 64'd0);

        // Idle with loader noise: nothing may be accepted or written.
        for (int c = 0; c < 20; c++) begin
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_data  = $urandom;
            fetch_addr   = $urandom;
            tick();
            chk("idle_hold", 64'(cpu_hold), 64'd1);
            chk("idle_ready", 64'(bus.ld_ready), 64'd0);
            chk("idle_instr", 64'(fetch_instr), 64'd0);
            chk("idle_done", 64'(load_done), 64'd0);
        end
        bus.ld_valid = 1'b0;

        // Directed four-word program with zero fill.
        ld_words[0] = 32'h2408_0000;
        ld_words[1] = 32'h2409_0000;
        ld_words[2] = 32'h240a_0000;
        ld_words[3] = 32'h240d_0000;
        do_load(4, 1'b1, 0, -1);
        fetch_chk(32'h0000_000C);
        chk("fetch_0c", 64'(fetch_instr), 64'h240d_0000);
        fetch_chk(32'h0000_040C);
        chk("fetch_40c", 64'(fetch_instr), 64'h240d_0000);
        fetch_chk(32'h0000_0010);
        chk("fetch_nop", 64'(fetch_instr), 64'd0);
        fetch_chk(32'h0000_0006);
        for (int k = 0; k < 6; k++) fetch_chk($urandom);

        // Three words with the loader idling every other cycle.
        for (int i = 0; i < 3; i++) ld_words[i] = $urandom;
        do_load(3, 1'b1, 1, -1);
        for (int k = 0; k < 6; k++) fetch_chk($urandom_range(0, 31));

        // Overflow: every index filled, no ld_last.
        for (int i = 0; i < DEPTH; i++) ld_words[i] = $urandom;
        do_load(DEPTH, 1'b0, 0, -1);
        repeat (3) begin
            bus.ld_valid = 1'b1;
            tick();
            chk("err_sticky", 64'(err_overflow), 64'd1);
            chk("ovf_ready", 64'(bus.ld_ready), 64'd0);
        end
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 6; k++) fetch_chk($urandom);

        // One-word program.
        ld_words[0] = $urandom;
        do_load(1, 1'b1, 2, -1);
        fetch_chk(32'h0);
        fetch_chk(32'h4);

        // Last beat exactly at the top index: no fill, no error.
        for (int i = 0; i < DEPTH; i++) ld_words[i] = $urandom;
        do_load(DEPTH, 1'b1, 0, -1);
        for (int k = 0; k < 6; k++) fetch_chk($urandom);

        // Random lengths with random loader gaps.
        repeat (2) begin
            int n;
            n = $urandom_range(5, 60);
            for (int i = 0; i < n; i++) ld_words[i] = $urandom;
            do_load(n, 1'b1, 2, -1);
            for (int k = 0; k < 6; k++) fetch_chk($urandom);
        end

        // Reload from RUN while fetching 0x10.
        fetch_addr = 32'h0000_0010;
        ld_words[0] = $urandom;
        ld_words[1] = $urandom;
        do_load(2, 1'b1, 0, -1);
        fetch_chk(32'h0000_0004);
        fetch_chk(32'h0000_0010);

        // Reset in the middle of the zero fill.
        for (int i = 0; i < 4; i++) ld_words[i] = $urandom;
        do_load(4, 1'b1, 0, 100);
        repeat (3) begin
            tick();
            chk("post_rst_hold", 64'(cpu_hold), 64'd1);
            chk("post_rst_we", 64'(bus.mem_we), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
